// File: rtl/div_error_monitor.sv
// Error monitor for a 16/8 array divider: checks n == q*d + r per sample and gathers run statistics.
// Optional build macro DIV_ERR_SSE_EN adds the squarer and sum-of-squared-error accumulator.
module div_error_monitor #(
   parameter int CNT_W = 16,
   parameter int SSE_W = 48
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] target,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      n,
   input  logic [7:0]       d,
   input  logic [7:0]       q,
   input  logic [7:0]       r,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] skip_count,
   output logic [16:0]      max_abs_err,
   output logic [SSE_W-1:0] sse
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] accepted;
   logic [CNT_W-1:0] target_reg;
   logic             drain_cnt;
   logic             accept;
   logic             last_accept;
   logic             start_run;

   logic             s1_valid;
   logic             s1_skip;
   logic [15:0]      s1_n;
   logic [16:0]      s1_recon;
   logic [16:0]      recon;

   logic signed [17:0] err;
   logic [17:0]        err_neg;
   logic [16:0]        abs_err;

   assign in_ready    = (state == RUN) && (accepted < target_reg);
   assign accept      = in_valid && in_ready;
   assign last_accept = accept && ((accepted + CNT_W'(1)) == target_reg);
   assign start_run   = start && ((state == IDLE) || (state == DONE));
   assign busy        = (state == RUN) || (state == DRAIN);
   assign done        = (state == DONE);

   // The last accept moves straight to DRAIN so the two drain cycles cover both pipeline stages.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if ((accepted == target_reg) || last_accept) state_next = DRAIN;
         DRAIN:   if (drain_cnt) state_next = DONE;
         DONE:    if (start) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         accepted   <= '0;
         target_reg <= '0;
         drain_cnt  <= 1'b0;
      end else begin
         state     <= state_next;
         drain_cnt <= (state == DRAIN);
         if (start_run) begin
            accepted   <= '0;
            target_reg <= target;
         end else if (accept) begin
            accepted <= accepted + CNT_W'(1);
         end
      end
   end

   assign recon = 17'(q) * 17'(d) + 17'(r);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_skip  <= 1'b0;
         s1_n     <= '0;
         s1_recon <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_n     <= n;
            s1_recon <= recon;
            s1_skip  <= (d == 8'd0) || (n[15:8] >= d);
         end
      end
   end

   assign err     = $signed({2'b00, s1_n}) - $signed({1'b0, s1_recon});
   assign err_neg = -err;
   assign abs_err = err[17] ? err_neg[16:0] : err[16:0];

   // Skipped samples (overflow or divide-by-zero) only bump skip_count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count   <= '0;
         skip_count  <= '0;
         max_abs_err <= '0;
      end else if (start_run) begin
         err_count   <= '0;
         skip_count  <= '0;
         max_abs_err <= '0;
      end else if (s1_valid) begin
         if (s1_skip) begin
            if (skip_count != '1) skip_count <= skip_count + CNT_W'(1);
         end else begin
            if ((err != 18'sd0) && (err_count != '1)) err_count <= err_count + CNT_W'(1);
            if (abs_err > max_abs_err) max_abs_err <= abs_err;
         end
      end
   end

`ifdef DIV_ERR_SSE_EN
   logic [33:0]      sq;
   logic [SSE_W:0]   sse_sum;
   logic [SSE_W-1:0] sse_reg;

   assign sq      = 34'(abs_err) * 34'(abs_err);
   assign sse_sum = {1'b0, sse_reg} + (SSE_W+1)'(sq);
   assign sse     = sse_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sse_reg <= '0;
      end else if (start_run) begin
         sse_reg <= '0;
      end else if (s1_valid && !s1_skip) begin
         sse_reg <= sse_sum[SSE_W] ? '1 : sse_sum[SSE_W-1:0];
      end
   end
`else
   assign sse = '0;
`endif

endmodule
